// File: rtl/pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller
//
// Central stall/flush sequencer for the 5-stage RV32IMF pipeline. Merges the
// data-memory busy, multi-cycle EX, taken-branch and load-use requests into
// per-stage hold (stall) and NOP-load (flush/bubble) controls. Owns the
// multi-cycle EX occupancy counter and a free-running stall-cycle counter.
//
// Parameters:
//   MC_CNT_W  width of EX_MC_LATENCY and the occupancy counter
//   PERF_W    width of STALL_CYCLES
//
// Ports:
//   CLK            clock, all state updates on the rising edge
//   RESET          synchronous, active-high reset
//   LU_HAZ_SIG     load-use hazard between ID and EX
//   BRANCH_TAKEN   EX-stage branch/jump resolved taken
//   DATA_MEM_BUSY  MEM-stage access not complete this cycle
//   EX_MC_START    ID/EX holds a multi-cycle operation
//   EX_MC_LATENCY  total EX cycles that operation needs (L)
//   PC_STALL       hold PC
//   IF_ID_STALL    hold IF/ID register
//   ID_EX_STALL    hold ID/EX register
//   EX_MEM_STALL   hold EX/MEM register
//   IF_ID_FLUSH    load NOP into IF/ID
//   ID_EX_BUBBLE   load NOP into ID/EX
//   EX_MEM_BUBBLE  load NOP into EX/MEM
//   MEM_WB_BUBBLE  load NOP into MEM/WB
//   MC_BUSY        a multi-cycle EX operation is occupying EX
//   STALL_CYCLES   number of cycles with PC_STALL=1, wraps
// ---------------------------------------------------------------------------
module pipeline_stall_controller #(
    parameter int unsigned MC_CNT_W = 5,
    parameter int unsigned PERF_W   = 32
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                LU_HAZ_SIG,
    input  logic                BRANCH_TAKEN,
    input  logic                DATA_MEM_BUSY,
    input  logic                EX_MC_START,
    input  logic [MC_CNT_W-1:0] EX_MC_LATENCY,
    output logic                PC_STALL,
    output logic                IF_ID_STALL,
    output logic                ID_EX_STALL,
    output logic                EX_MEM_STALL,
    output logic                IF_ID_FLUSH,
    output logic                ID_EX_BUBBLE,
    output logic                EX_MEM_BUBBLE,
    output logic                MEM_WB_BUBBLE,
    output logic                MC_BUSY,
    output logic [PERF_W-1:0]   STALL_CYCLES
);

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MC_BUSY = 1'b1;

    localparam logic [MC_CNT_W-1:0] LAT_TWO = MC_CNT_W'(2);
    localparam logic [MC_CNT_W-1:0] CNT_ONE = MC_CNT_W'(1);

    logic [0:0]          state_q, state_d;
    logic [MC_CNT_W-1:0] cnt_q, cnt_d;
    logic [PERF_W-1:0]   stall_cycles_q, stall_cycles_d;

    logic mc_launch;
    assign mc_launch = (state_q == ST_RUN) && EX_MC_START && (EX_MC_LATENCY >= LAT_TWO);

    // Control outputs and next state, one priority case per cycle.
    always_comb begin
        PC_STALL      = 1'b0;
        IF_ID_STALL   = 1'b0;
        ID_EX_STALL   = 1'b0;
        EX_MEM_STALL  = 1'b0;
        IF_ID_FLUSH   = 1'b0;
        ID_EX_BUBBLE  = 1'b0;
        EX_MEM_BUBBLE = 1'b0;
        MEM_WB_BUBBLE = 1'b0;
        state_d       = state_q;
        cnt_d         = cnt_q;

        if (RESET) begin
            // Flush every stage while reset is held; nothing is stalled.
            IF_ID_FLUSH   = 1'b1;
            ID_EX_BUBBLE  = 1'b1;
            EX_MEM_BUBBLE = 1'b1;
            MEM_WB_BUBBLE = 1'b1;
            state_d       = ST_RUN;
            cnt_d         = '0;
        end else if (DATA_MEM_BUSY) begin
            // Freeze the whole front of the pipe. A running multi-cycle unit
            // keeps counting down, but the state is held so the release cycle
            // is only taken once memory frees up.
            PC_STALL      = 1'b1;
            IF_ID_STALL   = 1'b1;
            ID_EX_STALL   = 1'b1;
            EX_MEM_STALL  = 1'b1;
            MEM_WB_BUBBLE = 1'b1;
            if ((state_q == ST_MC_BUSY) && (cnt_q != '0)) begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end else if (mc_launch) begin
            // First EX cycle of the operation; remaining stall cycles = L-2
            // after this one, then one release cycle.
            PC_STALL      = 1'b1;
            IF_ID_STALL   = 1'b1;
            ID_EX_STALL   = 1'b1;
            EX_MEM_BUBBLE = 1'b1;
            state_d       = ST_MC_BUSY;
            cnt_d         = EX_MC_LATENCY - LAT_TWO;
        end else if (state_q == ST_MC_BUSY) begin
            if (cnt_q != '0) begin
                PC_STALL      = 1'b1;
                IF_ID_STALL   = 1'b1;
                ID_EX_STALL   = 1'b1;
                EX_MEM_BUBBLE = 1'b1;
                cnt_d         = cnt_q - CNT_ONE;
            end else begin
                // Release cycle: result leaves EX, a new start is not accepted.
                state_d = ST_RUN;
            end
        end else if (BRANCH_TAKEN) begin
            // Wrong-path instructions in IF/ID and ID are squashed; the PC is
            // left free so the redirect target loads. Wins over load-use.
            IF_ID_FLUSH  = 1'b1;
            ID_EX_BUBBLE = 1'b1;
        end else if (LU_HAZ_SIG) begin
            PC_STALL     = 1'b1;
            IF_ID_STALL  = 1'b1;
            ID_EX_BUBBLE = 1'b1;
        end
    end

    assign MC_BUSY = ~RESET && (state_q == ST_MC_BUSY);

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (PC_STALL) begin
            stall_cycles_d = stall_cycles_q + PERF_W'(1);
        end
    end

    assign STALL_CYCLES = stall_cycles_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q        <= ST_RUN;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_controller
//
// Directed bench for pipeline_stall_controller. Two instances share inputs:
// the default configuration and a PERF_W=4 copy for the counter-wrap case.
// Output vector order: {PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL,
// IF_ID_FLUSH, ID_EX_BUBBLE, EX_MEM_BUBBLE, MEM_WB_BUBBLE, MC_BUSY}.
// ---------------------------------------------------------------------------
module tb_pipeline_stall_controller;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       LU_HAZ_SIG;
    logic       BRANCH_TAKEN;
    logic       DATA_MEM_BUSY;
    logic       EX_MC_START;
    logic [4:0] EX_MC_LATENCY;

    logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic        if_id_flush, id_ex_bubble, ex_mem_bubble, mem_wb_bubble, mc_busy;
    logic [31:0] stall_cycles;

    logic        pc_stall_s, if_id_stall_s, id_ex_stall_s, ex_mem_stall_s;
    logic        if_id_flush_s, id_ex_bubble_s, ex_mem_bubble_s, mem_wb_bubble_s, mc_busy_s;
    logic [3:0]  stall_cycles_s;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 CLK = ~CLK;

    pipeline_stall_controller #(.MC_CNT_W(5), .PERF_W(32)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .LU_HAZ_SIG   (LU_HAZ_SIG),
        .BRANCH_TAKEN (BRANCH_TAKEN),
        .DATA_MEM_BUSY(DATA_MEM_BUSY),
        .EX_MC_START  (EX_MC_START),
        .EX_MC_LATENCY(EX_MC_LATENCY),
        .PC_STALL     (pc_stall),
        .IF_ID_STALL  (if_id_stall),
        .ID_EX_STALL  (id_ex_stall),
        .EX_MEM_STALL (ex_mem_stall),
        .IF_ID_FLUSH  (if_id_flush),
        .ID_EX_BUBBLE (id_ex_bubble),
        .EX_MEM_BUBBLE(ex_mem_bubble),
        .MEM_WB_BUBBLE(mem_wb_bubble),
        .MC_BUSY      (mc_busy),
        .STALL_CYCLES (stall_cycles)
    );

    pipeline_stall_controller #(.MC_CNT_W(5), .PERF_W(4)) dut_w4 (
        .CLK          (CLK),
        .RESET        (RESET),
        .LU_HAZ_SIG   (LU_HAZ_SIG),
        .BRANCH_TAKEN (BRANCH_TAKEN),
        .DATA_MEM_BUSY(DATA_MEM_BUSY),
        .EX_MC_START  (EX_MC_START),
        .EX_MC_LATENCY(EX_MC_LATENCY),
        .PC_STALL     (pc_stall_s),
        .IF_ID_STALL  (if_id_stall_s),
        .ID_EX_STALL  (id_ex_stall_s),
        .EX_MEM_STALL (ex_mem_stall_s),
        .IF_ID_FLUSH  (if_id_flush_s),
        .ID_EX_BUBBLE (id_ex_bubble_s),
        .EX_MEM_BUBBLE(ex_mem_bubble_s),
        .MEM_WB_BUBBLE(mem_wb_bubble_s),
        .MC_BUSY      (mc_busy_s),
        .STALL_CYCLES (stall_cycles_s)
    );

    logic [8:0] outv, outv_s;
    assign outv   = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                     if_id_flush, id_ex_bubble, ex_mem_bubble, mem_wb_bubble, mc_busy};
    assign outv_s = {pc_stall_s, if_id_stall_s, id_ex_stall_s, ex_mem_stall_s,
                     if_id_flush_s, id_ex_bubble_s, ex_mem_bubble_s, mem_wb_bubble_s, mc_busy_s};

    localparam logic [8:0] O_IDLE  = 9'b0000_0000_0;
    localparam logic [8:0] O_RST   = 9'b0000_1111_0;
    localparam logic [8:0] O_LU    = 9'b1100_0100_0;
    localparam logic [8:0] O_MC0   = 9'b1110_0010_0;  // launch cycle, still RUN
    localparam logic [8:0] O_MC    = 9'b1110_0010_1;  // stalling in MC_BUSY
    localparam logic [8:0] O_REL   = 9'b0000_0000_1;  // release cycle
    localparam logic [8:0] O_MEMMC = 9'b1111_0001_1;  // memory freeze in MC_BUSY
    localparam logic [8:0] O_MEM   = 9'b1111_0001_0;  // memory freeze in RUN
    localparam logic [8:0] O_BR    = 9'b0000_1100_0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, check combinational outputs of both
    // instances, then advance to the next falling edge (one rising edge
    // passes in between).
    task automatic cyc(input string tag, input logic rst, input logic lu, input logic br,
                       input logic mb, input logic mcs, input logic [4:0] lat,
                       input logic [8:0] exp);
        RESET         = rst;
        LU_HAZ_SIG    = lu;
        BRANCH_TAKEN  = br;
        DATA_MEM_BUSY = mb;
        EX_MC_START   = mcs;
        EX_MC_LATENCY = lat;
        #1;
        check_eq(tag, 32'(outv), 32'(exp));
        check_eq({tag, "_w4"}, 32'(outv_s), 32'(exp));
        @(negedge CLK);
    endtask

    initial begin
        // Reset with every input asserted.
        cyc("rst1", 1, 1, 1, 1, 1, 5'd31, O_RST);
        RESET = 1'b1;
        #1;
        check_eq("rst_cnt", stall_cycles, 32'd0);
        check_eq("rst_cnt_w4", 32'(stall_cycles_s), 32'd0);
        cyc("rst2", 1, 1, 1, 1, 1, 5'd31, O_RST);
        cyc("post_rst", 0, 0, 0, 0, 0, 5'd0, O_IDLE);
        check_eq("cnt_after_rst", stall_cycles, 32'd0);

        // Load-use one-cycle bubble.
        cyc("lu", 0, 1, 0, 0, 0, 5'd0, O_LU);
        cyc("lu_after", 0, 0, 0, 0, 0, 5'd0, O_IDLE);
        check_eq("cnt_lu", stall_cycles, 32'd1);

        // Multi-cycle L=5, start held through the release cycle.
        cyc("mc5_c1", 0, 0, 0, 0, 1, 5'd5, O_MC0);
        cyc("mc5_c2", 0, 0, 0, 0, 1, 5'd5, O_MC);
        cyc("mc5_c3", 0, 0, 0, 0, 1, 5'd5, O_MC);
        cyc("mc5_c4", 0, 0, 0, 0, 1, 5'd5, O_MC);
        cyc("mc5_rel", 0, 0, 0, 0, 1, 5'd5, O_REL);
        cyc("mc5_run", 0, 0, 0, 0, 0, 5'd5, O_IDLE);
        check_eq("cnt_mc5", stall_cycles, 32'd5);

        // L=2: single stall cycle then release.
        cyc("mc2_c1", 0, 0, 0, 0, 1, 5'd2, O_MC0);
        cyc("mc2_rel", 0, 0, 0, 0, 1, 5'd2, O_REL);
        cyc("mc2_run", 0, 0, 0, 0, 0, 5'd2, O_IDLE);
        check_eq("cnt_mc2", stall_cycles, 32'd6);

        // L=1 and L=0 are single-cycle: no action.
        cyc("mc1", 0, 0, 0, 0, 1, 5'd1, O_IDLE);
        cyc("mc0", 0, 0, 0, 0, 1, 5'd0, O_IDLE);
        cyc("mc01_run", 0, 0, 0, 0, 0, 5'd0, O_IDLE);
        check_eq("cnt_mc1", stall_cycles, 32'd6);

        // L=4 with memory busy in cycles 2-6; cnt reaches 0 during the freeze.
        cyc("mcm_c1", 0, 0, 0, 0, 1, 5'd4, O_MC0);
        for (int i = 2; i <= 6; i++) begin
            cyc($sformatf("mcm_c%0d", i), 0, 1, 1, 1, 1, 5'd4, O_MEMMC);
        end
        cyc("mcm_rel", 0, 0, 0, 0, 1, 5'd4, O_REL);
        cyc("mcm_run", 0, 0, 0, 0, 0, 5'd4, O_IDLE);
        check_eq("cnt_mcm", stall_cycles, 32'd12);

        // Branch beats load-use; under memory busy only the freeze applies.
        cyc("br_lu", 0, 1, 1, 0, 0, 5'd0, O_BR);
        cyc("br_lu_mb", 0, 1, 1, 1, 0, 5'd0, O_MEM);
        cyc("br_lu_after_mb", 0, 1, 1, 0, 0, 5'd0, O_BR);
        cyc("br_idle", 0, 0, 0, 0, 0, 5'd0, O_IDLE);
        check_eq("cnt_br", stall_cycles, 32'd13);

        // Reset in MC_BUSY aborts the operation.
        cyc("abort_c1", 0, 0, 0, 0, 1, 5'd5, O_MC0);
        cyc("abort_c2", 0, 0, 0, 0, 0, 5'd5, O_MC);
        cyc("abort_rst", 1, 0, 0, 0, 0, 5'd5, O_RST);
        cyc("abort_run", 0, 0, 0, 0, 0, 5'd5, O_IDLE);
        check_eq("cnt_abort", stall_cycles, 32'd0);

        // 17 load-use stalls: 17 on the wide counter, 17 mod 16 = 1 on PERF_W=4.
        for (int i = 0; i < 17; i++) begin
            cyc("wrap_lu", 0, 1, 0, 0, 0, 5'd0, O_LU);
        end
        cyc("wrap_idle", 0, 0, 0, 0, 0, 5'd0, O_IDLE);
        check_eq("cnt_wrap32", stall_cycles, 32'd17);
        check_eq("cnt_wrap4", 32'(stall_cycles_s), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
